// File: rtl/bin2bcd_seq_ctrl_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The requester drives master. The converter implements slave.
interface bin2bcd_seq_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start_i;
  logic [WIDTH-1:0]      bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  overflow_o;

  modport master (
    output start_i, bin_i,
    input  busy_o, done_o, bcd_o, overflow_o
  );

  modport slave (
    input  start_i, bin_i,
    output busy_o, done_o, bcd_o, overflow_o
  );
endinterface

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Results hold until the next conversion completes; overflow flags truncated digits.
module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  bin2bcd_seq_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]   work, work_corr, work_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               ovf, ovf_nxt;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               load, last_step;

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    r = w;
    for (int d = 0; d < DIGITS; d++) begin
      if (w[4*d +: 4] >= 4'd5)
        r[4*d +: 4] = w[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Correct every digit, then shift the next binary bit into the units digit.
  always_comb begin
    work_corr = add3_all(work);
    work_nxt  = {work_corr[BCD_W-2:0], bin_sr[WIDTH-1]};
    ovf_nxt   = ovf | work_corr[BCD_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    last_step  = 1'b0;
    bus.busy_o = 1'b0;
    bus.done_o = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy_o = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr <= '0;
      work   <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      bin_sr <= bus.bin_i;
      work   <= '0;
      cnt    <= CNT_W'(WIDTH);
      ovf    <= 1'b0;
    end else if (state == SHIFT) begin
      bin_sr <= bin_sr << 1;
      work   <= work_nxt;
      cnt    <= cnt - CNT_W'(1);
      ovf    <= ovf_nxt;
      if (last_step) begin
        bcd_q <= work_nxt;
        ovf_q <= ovf_nxt;
      end
    end
  end

  assign bus.bcd_o      = bcd_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Scoreboard bench for three converter configurations (16/5, 16/4, 8/3) on one clock.
module tb_bin2bcd_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  typedef struct {
    logic [63:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        q[3][$];
  logic [63:0] last_bcd[3];
  int          busy_n[3];

  bin2bcd_seq_ctrl_if #(.WIDTH(16), .DIGITS(5)) ifa ();
  bin2bcd_seq_ctrl_if #(.WIDTH(16), .DIGITS(4)) ifb ();
  bin2bcd_seq_ctrl_if #(.WIDTH(8),  .DIGITS(3)) ifc ();

  bin2bcd_seq_ctrl #(.WIDTH(16), .DIGITS(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bin2bcd_seq_ctrl #(.WIDTH(16), .DIGITS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  bin2bcd_seq_ctrl #(.WIDTH(8),  .DIGITS(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] to_bcd(input int unsigned v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic too_big(input int unsigned v, input int digits);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (longint'(v) >= lim);
  endfunction

  function automatic int width_of(input int id);
    return (id == 2) ? 8 : 16;
  endfunction

  function automatic int digits_of(input int id);
    return (id == 0) ? 5 : (id == 1) ? 4 : 3;
  endfunction

  task automatic drive(input int id, input logic s, input int unsigned v);
    case (id)
      0: begin ifa.start_i = s; ifa.bin_i = 16'(v); end
      1: begin ifb.start_i = s; ifb.bin_i = 16'(v); end
      default: begin ifc.start_i = s; ifc.bin_i = 8'(v); end
    endcase
  endtask

  task automatic start(input int id, input int unsigned v, input bit accept);
    exp_t e;
    @(negedge clk);
    drive(id, 1'b1, v);
    if (accept) begin
      e.bcd = to_bcd(v, digits_of(id));
      e.ovf = too_big(v, digits_of(id));
      e.acc = cyc + 1;
      q[id].push_back(e);
    end
    @(negedge clk);
    drive(id, 1'b0, v);
  endtask

  task automatic convert(input int id, input int unsigned v);
    start(id, v, 1'b1);
    repeat (width_of(id)) @(negedge clk);
  endtask

  task automatic observe(input int id, input logic done, input logic busy,
                         input logic [63:0] bcd, input logic ovf);
    exp_t e;
    string s;
    if (busy) begin
      busy_n[id]++;
      s = $sformatf("hold%0d", id);
      check(s, bcd, last_bcd[id]);
    end
    if (done) begin
      if (q[id].size() == 0) begin
        s = $sformatf("spurious_done%0d", id);
        check(s, 64'(done), 64'd0);
      end else begin
        e = q[id].pop_front();
        s = $sformatf("bcd%0d", id);
        check(s, bcd, e.bcd);
        s = $sformatf("ovf%0d", id);
        check(s, 64'(ovf), 64'(e.ovf));
        s = $sformatf("latency%0d", id);
        check(s, 64'(cyc - e.acc), 64'(width_of(id)));
        s = $sformatf("busy_len%0d", id);
        check(s, 64'(busy_n[id]), 64'(width_of(id)));
        last_bcd[id] = e.bcd;
      end
      busy_n[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      observe(0, ifa.done_o, ifa.busy_o, 64'(ifa.bcd_o), ifa.overflow_o);
      observe(1, ifb.done_o, ifb.busy_o, 64'(ifb.bcd_o), ifb.overflow_o);
      observe(2, ifc.done_o, ifc.busy_o, 64'(ifc.bcd_o), ifc.overflow_o);
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'({ifa.busy_o, ifb.busy_o, ifc.busy_o}), 64'd0);
    check({tag, "_done"}, 64'({ifa.done_o, ifb.done_o, ifc.done_o}), 64'd0);
    check({tag, "_bcd_a"}, 64'(ifa.bcd_o), 64'd0);
    check({tag, "_bcd_bc"}, 64'({ifb.bcd_o, ifc.bcd_o}), 64'd0);
    check({tag, "_ovf"}, 64'({ifa.overflow_o, ifb.overflow_o, ifc.overflow_o}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_bcd[i] = '0;
      busy_n[i]   = 0;
      drive(i, 1'b0, 0);
    end
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 16-bit / 5-digit conversions, result held across the next one
    convert(0, 0);
    convert(0, 65535);
    convert(0, 1234);

    // 4-digit truncation boundaries
    convert(1, 12345);
    convert(1, 9999);
    convert(1, 10000);

    // Starts during SHIFT and DONE are dropped; first IDLE start is taken
    start(0, 100, 1'b1);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 999);
    @(negedge clk);
    drive(0, 1'b0, 999);
    repeat (13) @(negedge clk);
    drive(0, 1'b1, 777);
    start(0, 4321, 1'b1);
    repeat (16) @(negedge clk);

    // Asynchronous reset in the middle of a conversion
    start(0, 40000, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    check("busy_before_abort", 64'(ifa.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    for (int i = 0; i < 3; i++) begin
      last_bcd[i] = '0;
      busy_n[i]   = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    convert(0, 255);

    // Exhaustive 8-bit sweep
    for (int v = 0; v < 256; v++) convert(2, v);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("pending%0d", i), 64'(q[i].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
